// File: rtl/nes_host_ctrl_pkg.sv
// Shared types for the NES host control block: opcodes, controller states,
// queued command layout and status-byte bit positions.
package nes_host_ctrl_pkg;

    localparam int NES_ADDR_W = 16;

    typedef enum logic [7:0] {
        OP_RESET     = 8'h00,
        OP_START     = 8'h01,
        OP_PAUSE     = 8'h02,
        OP_WRITE_MEM = 8'h03,
        OP_WRITE_INC = 8'h04,
        OP_SET_PTR   = 8'h05,
        OP_READ_MEM  = 8'h06,
        OP_STEP      = 8'h07
    } nes_op_e;

    typedef logic [2:0] ctrl_state_e;

    localparam ctrl_state_e S_RESET = 3'd0;
    localparam ctrl_state_e S_PAUSE = 3'd1;
    localparam ctrl_state_e S_RUN   = 3'd2;
    localparam ctrl_state_e S_STEP  = 3'd3;
    localparam ctrl_state_e S_MEMRD = 3'd4;

    typedef struct packed {
        nes_op_e                 op;
        logic [NES_ADDR_W-1:0]   addr;
        logic [7:0]              data;
    } cmd_t;

    localparam int ST_OVF   = 7;
    localparam int ST_ERR   = 6;
    localparam int ST_FULL  = 5;
    localparam int ST_EMPTY = 4;

    function automatic logic [7:0] pack_status(input logic ovf, input logic err,
                                               input logic full, input logic empty,
                                               input ctrl_state_e st);
        logic [7:0] s;
        s           = {5'b00000, st};
        s[ST_OVF]   = ovf;
        s[ST_ERR]   = err;
        s[ST_FULL]  = full;
        s[ST_EMPTY] = empty;
        return s;
    endfunction

    // Ops that touch memory or hand the bus to the CPU; refused while running.
    function automatic logic is_mem_op(input nes_op_e op);
        return (op == OP_WRITE_MEM) || (op == OP_WRITE_INC) ||
               (op == OP_READ_MEM)  || (op == OP_STEP);
    endfunction

endpackage

// File: rtl/nes_host_ctrl_if.sv
// Host (Avalon-style slave) bus bundle between the HPS bridge and nes_host_ctrl.
interface nes_host_ctrl_if #(
    parameter int ADDR_W = 16
) ();
    logic              chipselect;
    logic              write;
    logic              read;
    logic [ADDR_W-1:0] address;
    logic [15:0]       writedata;
    logic [7:0]        readdata;

    modport master (
        output chipselect, write, read, address, writedata,
        input  readdata
    );

    modport slave (
        input  chipselect, write, read, address, writedata,
        output readdata
    );
endinterface

// File: rtl/nes_host_ctrl_cmd_fifo.sv
// Synchronous fall-through command FIFO; head entry is visible on rdata_o while
// not empty. A push into a full FIFO is accepted only if a pop frees a slot.
module nes_host_ctrl_cmd_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             wr_en_s, rd_en_s;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == (AW+1)'(0));
    assign rdata_o = mem_q[rd_ptr_q];
    assign rd_en_s = pop_i & ~empty_o;
    assign wr_en_s = push_i & (~full_o | rd_en_s);

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_en_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_en_s, rd_en_s})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= AW'(0);
            rd_ptr_q <= AW'(0);
            count_q  <= (AW+1)'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care while the slot is unoccupied.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/nes_host_ctrl.sv
// Host-to-NES control: queues host commands, drives CPU reset/run/step, muxes
// the program memory port between host and CPU, and serves status/readback.
module nes_host_ctrl
    import nes_host_ctrl_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int STEP_W     = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    nes_host_ctrl_if.slave    host,
    output logic              cpu_reset,
    output logic              cpu_ready,
    input  logic [15:0]       cpu_addr,
    input  logic              cpu_write,
    input  logic [7:0]        cpu_dout,
    output logic [7:0]        cpu_din,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);
    ctrl_state_e       state_q, state_d, ret_q, ret_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d, rdaddr_q, rdaddr_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [7:0]        rd_data_q, rd_data_d, readdata_q, readdata_d;
    logic              ovf_q, ovf_d, err_q, err_d;
    logic              cpu_reset_q, cpu_reset_d, cpu_ready_q, cpu_ready_d;

    cmd_t              push_cmd_s, head_s;
    logic              push_s, pop_s, rd_s, full_s, empty_s;
    logic              err_set_s, ovf_set_s, st_clr_s;
    logic              host_we_s;
    logic [ADDR_W-1:0] host_addr_s;
    logic [7:0]        host_wdata_s;

    assign push_s     = host.chipselect & host.write;
    assign rd_s       = host.chipselect & host.read;
    assign push_cmd_s = '{op: nes_op_e'(host.writedata[15:8]),
                          addr: host.address,
                          data: host.writedata[7:0]};
    assign pop_s      = ~empty_s & (state_q inside {S_RESET, S_PAUSE, S_RUN});

    nes_host_ctrl_cmd_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push_s),
        .wdata_i (push_cmd_s),
        .pop_i   (pop_s),
        .rdata_o (head_s),
        .full_o  (full_s),
        .empty_o (empty_s)
    );

    // Controller FSM: command execution, stepping and memory readback.
    always_comb begin
        state_d      = state_q;
        ret_d        = ret_q;
        ptr_d        = ptr_q;
        rdaddr_d     = rdaddr_q;
        step_d       = step_q;
        rd_data_d    = rd_data_q;
        err_set_s    = 1'b0;
        host_we_s    = 1'b0;
        host_addr_s  = ptr_q;
        host_wdata_s = 8'h00;
        case (state_q)
            S_STEP: begin
                step_d = step_q - STEP_W'(1);
                if (step_q <= STEP_W'(1)) begin
                    state_d = S_PAUSE;
                end else begin
                    state_d = S_STEP;
                end
            end
            S_MEMRD: begin
                host_addr_s = rdaddr_q;
                rd_data_d   = mem_rdata;
                state_d     = ret_q;
            end
            default: begin
                if (!pop_s) begin
                    state_d = state_q;
                end else if (is_mem_op(head_s.op) && (state_q == S_RUN)) begin
                    err_set_s = 1'b1;
                end else begin
                    case (head_s.op)
                        OP_RESET: state_d = S_RESET;
                        OP_START: state_d = S_RUN;
                        OP_PAUSE: state_d = S_PAUSE;
                        OP_WRITE_MEM: begin
                            host_we_s    = 1'b1;
                            host_addr_s  = head_s.addr;
                            host_wdata_s = head_s.data;
                        end
                        OP_WRITE_INC: begin
                            host_we_s    = 1'b1;
                            host_addr_s  = ptr_q;
                            host_wdata_s = head_s.data;
                            ptr_d        = ptr_q + ADDR_W'(1);
                        end
                        OP_SET_PTR: ptr_d = head_s.addr;
                        OP_READ_MEM: begin
                            host_addr_s = head_s.addr;
                            rdaddr_d    = head_s.addr;
                            ret_d       = state_q;
                            state_d     = S_MEMRD;
                        end
                        OP_STEP: begin
                            if (head_s.data != 8'h00) begin
                                step_d  = STEP_W'(head_s.data);
                                state_d = S_STEP;
                            end else begin
                                state_d = state_q;
                            end
                        end
                        default: err_set_s = 1'b1;
                    endcase
                end
            end
        endcase
    end

    // Sticky flags, registered readback and CPU control decode.
    always_comb begin
        ovf_set_s   = push_s & full_s & ~pop_s;
        st_clr_s    = rd_s & ~host.address[0];
        ovf_d       = ovf_set_s | (ovf_q & ~st_clr_s);
        err_d       = err_set_s | (err_q & ~st_clr_s);
        cpu_reset_d = (state_d == S_RESET);
        cpu_ready_d = (state_d == S_RUN) || (state_d == S_STEP);
        if (!rd_s) begin
            readdata_d = readdata_q;
        end else if (host.address[0]) begin
            readdata_d = rd_data_q;
        end else begin
            readdata_d = pack_status(ovf_q, err_q, full_s, empty_s, state_q);
        end
    end

    // Controller state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_RESET;
            ret_q       <= S_RESET;
            ptr_q       <= ADDR_W'(0);
            rdaddr_q    <= ADDR_W'(0);
            step_q      <= STEP_W'(0);
            rd_data_q   <= 8'h00;
            readdata_q  <= 8'h00;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
            cpu_reset_q <= 1'b1;
            cpu_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            ptr_q       <= ptr_d;
            rdaddr_q    <= rdaddr_d;
            step_q      <= step_d;
            rd_data_q   <= rd_data_d;
            readdata_q  <= readdata_d;
            ovf_q       <= ovf_d;
            err_q       <= err_d;
            cpu_reset_q <= cpu_reset_d;
            cpu_ready_q <= cpu_ready_d;
        end
    end

    assign host.readdata = readdata_q;
    assign cpu_reset     = cpu_reset_q;
    assign cpu_ready     = cpu_ready_q;
    assign cpu_din       = mem_rdata;

    // The CPU owns memory whenever it is allowed to run.
    assign mem_addr  = cpu_ready_q ? cpu_addr  : host_addr_s;
    assign mem_write = cpu_ready_q ? cpu_write : host_we_s;
    assign mem_wdata = cpu_ready_q ? cpu_dout  : host_wdata_s;

endmodule

// File: tb/tb_nes_host_ctrl.sv
// Directed self-checking bench for nes_host_ctrl with a synchronous-read memory model.
module tb_nes_host_ctrl;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic        cpu_write = 1'b0;
    logic [7:0]  cpu_dout = 8'h00;
    logic [7:0]  cpu_din;
    logic        cpu_reset, cpu_ready;
    logic [15:0] mem_addr;
    logic        mem_write;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic [7:0]  mem [65536];

    int checks = 0;
    int errors = 0;

    nes_host_ctrl_if #(.ADDR_W(16)) bus ();

    nes_host_ctrl #(.ADDR_W(16), .FIFO_DEPTH(8), .STEP_W(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .host      (bus),
        .cpu_reset (cpu_reset),
        .cpu_ready (cpu_ready),
        .cpu_addr  (cpu_addr),
        .cpu_write (cpu_write),
        .cpu_dout  (cpu_dout),
        .cpu_din   (cpu_din),
        .mem_addr  (mem_addr),
        .mem_write (mem_write),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic host_write(input logic [7:0] op, input logic [15:0] addr, input logic [7:0] data);
        @(negedge clk);
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        bus.read       = 1'b0;
        bus.address    = addr;
        bus.writedata  = {op, data};
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.chipselect = 1'b0;
            bus.write      = 1'b0;
            bus.read       = 1'b0;
        end
    endtask

    task automatic host_read(input logic sel, output logic [7:0] data);
        @(negedge clk);
        bus.chipselect = 1'b1;
        bus.write      = 1'b0;
        bus.read       = 1'b1;
        bus.address    = {15'h0000, sel};
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        data = bus.readdata;
    endtask

    initial begin
        logic [7:0] rd;
        int         ready_cnt;
        logic       any_we;

        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
        bus.read       = 1'b0;
        bus.address    = 16'h0000;
        bus.writedata  = 16'h0000;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check_eq("rst_cpu_ready", {31'd0, cpu_ready}, 32'd0);
        check_eq("rst_readdata", {24'd0, bus.readdata}, 32'h00);
        reset_n = 1'b1;
        host_read(1'b0, rd);
        check_eq("status_after_reset", {24'd0, rd}, 32'h10);

        // Pointer writes and readback
        host_write(8'h05, 16'h8000, 8'h00);
        host_write(8'h04, 16'h0000, 8'hA9);
        host_write(8'h04, 16'h0000, 8'h01);
        host_write(8'h04, 16'h0000, 8'hEA);
        host_write(8'h06, 16'h8001, 8'h00);
        idle(5);
        check_eq("mem_8000", {24'd0, mem[16'h8000]}, 32'hA9);
        check_eq("mem_8001", {24'd0, mem[16'h8001]}, 32'h01);
        check_eq("mem_8002", {24'd0, mem[16'h8002]}, 32'hEA);
        host_read(1'b1, rd);
        check_eq("rd_data_8001", {24'd0, rd}, 32'h01);
        host_write(8'h04, 16'h0000, 8'h55);
        idle(3);
        check_eq("ptr_is_8003", {24'd0, mem[16'h8003]}, 32'h55);
        host_read(1'b0, rd);
        check_eq("status_reset_after_mem", {24'd0, rd}, 32'h10);

        // Pause, zero-step no-op, then 5-cycle step
        host_write(8'h02, 16'h0000, 8'h00);
        idle(2);
        host_read(1'b0, rd);
        check_eq("status_pause", {24'd0, rd}, 32'h11);
        host_write(8'h07, 16'h0000, 8'h00);
        idle(2);
        host_read(1'b0, rd);
        check_eq("status_step0_noop", {24'd0, rd}, 32'h11);
        host_write(8'h07, 16'h0000, 8'h05);
        idle(1);
        ready_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cpu_ready) ready_cnt++;
        end
        check_eq("step5_ready_cycles", ready_cnt, 32'd5);
        host_read(1'b0, rd);
        check_eq("status_after_step", {24'd0, rd}, 32'h11);

        // Overflow while stepping: 9 back-to-back pushes into depth 8
        host_write(8'h07, 16'h0000, 8'd200);
        idle(3);
        check_eq("step200_ready", {31'd0, cpu_ready}, 32'd1);
        for (int i = 0; i < 9; i++) host_write(8'h02, 16'h0000, 8'h00);
        idle(1);
        host_read(1'b0, rd);
        check_eq("status_ovf_full", {24'd0, rd}, 32'hA3);
        host_read(1'b0, rd);
        check_eq("status_ovf_cleared", {24'd0, rd}, 32'h23);

        // Asynchronous reset mid-step
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_eq("midstep_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check_eq("midstep_cpu_ready", {31'd0, cpu_ready}, 32'd0);
        check_eq("midstep_readdata", {24'd0, bus.readdata}, 32'h00);
        @(negedge clk);
        reset_n = 1'b1;
        idle(2);
        host_read(1'b0, rd);
        check_eq("status_after_midstep_reset", {24'd0, rd}, 32'h10);

        // Memory op while running is refused; CPU owns the memory port
        cpu_addr  = 16'h4321;
        cpu_write = 1'b0;
        cpu_dout  = 8'h3C;
        host_write(8'h01, 16'h0000, 8'h00);
        host_write(8'h03, 16'h1234, 8'h77);
        any_we = 1'b0;
        for (int i = 0; i < 6; i++) begin
            idle(1);
            any_we = any_we | mem_write;
        end
        check_eq("run_no_mem_write", {31'd0, any_we}, 32'd0);
        check_eq("run_mem_addr_cpu", {16'd0, mem_addr}, 32'h4321);
        check_eq("run_mem_1234_untouched", {24'd0, mem[16'h1234]}, 32'h00);
        cpu_write = 1'b1;
        #1;
        check_eq("run_mem_write_cpu", {31'd0, mem_write}, 32'd1);
        check_eq("run_mem_wdata_cpu", {24'd0, mem_wdata}, 32'h3C);
        cpu_write = 1'b0;
        host_read(1'b0, rd);
        check_eq("status_run_err", {24'd0, rd}, 32'h52);
        host_read(1'b0, rd);
        check_eq("status_err_cleared", {24'd0, rd}, 32'h12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
